// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 4-bit ALU and its BIST controller.
//   - ALU opcode encodings (ADD/SUB/MUL/DIV)
//   - BIST controller state type (IDLE/APPLY/CAPTURE/DONE)
//   - divide-by-zero result constant
//   - MISR polynomial/seed and a single-step MISR update helper
package alu_pkg;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      MUL = 2'b10,
      DIV = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      APPLY   = 2'b01,
      CAPTURE = 2'b10,
      DONE    = 2'b11
   } bist_state_e;

   localparam logic [3:0]  DIV_BY_ZERO_RESULT = 4'hF;

   // x^16 + x^12 + x^5 + 1 (the x^16 term is implied by the shift-out)
   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_SEED = 16'hFFFF;

   // One MISR clock: Galois shift with feedback, then fold in the 4-bit data word.
   function automatic logic [15:0] misr_step(input logic [15:0] cur, input logic [3:0] data);
      logic [15:0] shifted;
      shifted = {cur[14:0], 1'b0};
      if (cur[15]) begin
         shifted = shifted ^ MISR_POLY;
      end else begin
         shifted = shifted;
      end
      return shifted ^ {12'h000, data};
   endfunction

endpackage

// File: rtl/alu_golden_model.sv
// alu_golden_model: combinational 4-bit reference ALU used by the BIST
// controller to judge the real ALU's result.
// Ports:
//   a, b    in  4  operands
//   op      in  2  opcode (alu_pkg::alu_op_e encoding)
//   result  out 4  expected result, wrapping modulo 16; divide by zero gives 4'hF
module alu_golden_model
   import alu_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [1:0] op,
   output logic [3:0] result
);

   // Reference result; 4-bit arithmetic gives the modulo-16 wrap directly.
   always_comb begin
      result = 4'h0;
      case (alu_op_e'(op))
         ADD: result = a + b;
         SUB: result = a - b;
         MUL: result = a * b;
         DIV: begin
            if (b == 4'h0) begin
               result = DIV_BY_ZERO_RESULT;
            end else begin
               result = a / b;
            end
         end
         default: result = 4'h0;
      endcase
   end

endmodule

// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: built-in self-test controller for the 4-bit ALU.
// On start it walks vector index i = 0..NUM_VECTORS-1, driving
// {alu_a, alu_b, alu_op} = i, and compares alu_c with the golden model.
// Optional feature macro: ALU_BIST_MISR_EN adds a 16-bit MISR and the
// signature output.
// Ports:
//   clk, rst          clock, async active-high reset
//   start             run request (accepted in IDLE or DONE only)
//   alu_a/b/op        registered vector to the ALU
//   alu_c             ALU result
//   busy/done/pass    registered status
//   fault_flag        one-cycle pulse per mismatching vector
//   fault_count       saturating mismatch count
//   first_fail_vec    index of first mismatch
//   signature         MISR signature (ALU_BIST_MISR_EN only)
module alu_bist_ctrl
   import alu_pkg::*;
#(
   parameter int NUM_VECTORS = 1024,
   parameter int CNT_W       = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [1:0]       alu_op,
   input  logic [3:0]       alu_c,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fault_flag,
   output logic [CNT_W-1:0] fault_count,
`ifdef ALU_BIST_MISR_EN
   output logic [15:0]      signature,
`endif
   output logic [9:0]       first_fail_vec
);

   localparam logic [9:0] LAST_VEC = 10'(NUM_VECTORS - 1);

   bist_state_e      state_r, state_nxt_s;
   logic [9:0]       vec_r, vec_nxt_s;        // vector index, also the ALU stimulus
   logic [CNT_W-1:0] fault_cnt_r, fault_cnt_nxt_s;
   logic [9:0]       first_fail_r, first_fail_nxt_s;
   logic             fault_flag_r, fault_flag_nxt_s;
   logic             busy_r, done_r, pass_r;
   logic             start_ok_s;
   logic [3:0]       golden_s;
   logic             mismatch_s;

   alu_golden_model u_golden (
      .a      (vec_r[9:6]),
      .b      (vec_r[5:2]),
      .op     (vec_r[1:0]),
      .result (golden_s)
   );

   assign start_ok_s = start && ((state_r == IDLE) || (state_r == DONE));
   assign mismatch_s = (alu_c != golden_s);

   // Next-state, vector index and fault bookkeeping.
   always_comb begin
      state_nxt_s      = state_r;
      vec_nxt_s        = vec_r;
      fault_cnt_nxt_s  = fault_cnt_r;
      first_fail_nxt_s = first_fail_r;
      fault_flag_nxt_s = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (start_ok_s) begin
               state_nxt_s      = APPLY;
               vec_nxt_s        = 10'd0;
               fault_cnt_nxt_s  = {CNT_W{1'b0}};
               first_fail_nxt_s = 10'd0;
            end else begin
               state_nxt_s = state_r;
            end
         end
         APPLY: begin
            state_nxt_s = CAPTURE;
         end
         CAPTURE: begin
            if (mismatch_s) begin
               fault_flag_nxt_s = 1'b1;
               if (fault_cnt_r != {CNT_W{1'b1}}) begin
                  fault_cnt_nxt_s = fault_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  fault_cnt_nxt_s = fault_cnt_r;
               end
               if (fault_cnt_r == {CNT_W{1'b0}}) begin
                  first_fail_nxt_s = vec_r;
               end else begin
                  first_fail_nxt_s = first_fail_r;
               end
            end else begin
               fault_flag_nxt_s = 1'b0;
            end
            if (vec_r == LAST_VEC) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = APPLY;
               vec_nxt_s   = vec_r + 10'd1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, stimulus and status registers; status is decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         vec_r        <= 10'd0;
         fault_cnt_r  <= {CNT_W{1'b0}};
         first_fail_r <= 10'd0;
         fault_flag_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         vec_r        <= vec_nxt_s;
         fault_cnt_r  <= fault_cnt_nxt_s;
         first_fail_r <= first_fail_nxt_s;
         fault_flag_r <= fault_flag_nxt_s;
         busy_r       <= (state_nxt_s == APPLY) || (state_nxt_s == CAPTURE);
         done_r       <= (state_nxt_s == DONE);
         pass_r       <= (state_nxt_s == DONE) && (fault_cnt_nxt_s == {CNT_W{1'b0}});
      end
   end

   assign alu_a          = vec_r[9:6];
   assign alu_b          = vec_r[5:2];
   assign alu_op         = vec_r[1:0];
   assign busy           = busy_r;
   assign done           = done_r;
   assign pass           = pass_r;
   assign fault_flag     = fault_flag_r;
   assign fault_count    = fault_cnt_r;
   assign first_fail_vec = first_fail_r;

`ifdef ALU_BIST_MISR_EN
   logic [15:0] misr_r, misr_nxt_s;

   // MISR: seeded on an accepted start, absorbs alu_c each CAPTURE, frozen otherwise.
   always_comb begin
      misr_nxt_s = misr_r;
      if (start_ok_s) begin
         misr_nxt_s = MISR_SEED;
      end else if (state_r == CAPTURE) begin
         misr_nxt_s = misr_step(misr_r, alu_c);
      end else begin
         misr_nxt_s = misr_r;
      end
   end

   // MISR register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misr_r <= 16'h0000;
      end else begin
         misr_r <= misr_nxt_s;
      end
   end

   assign signature = misr_r;
`endif

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// tb_alu_bist_ctrl: self-checking bench for alu_bist_ctrl.
// A 1024-vector instance runs against a behavioural ALU with selectable
// faults (none, result bit 0 stuck-at-0, random per-vector corruption);
// expected counts come from an arithmetic model over the vector space.
// A 4-vector instance is checked cycle by cycle against a constant table.
module tb_alu_bist_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start4;
   int          fmode, fmode4;
   logic [3:0]  mask [1024];

   logic [3:0]  alu_a, alu_b, alu_c, gold_c;
   logic [1:0]  alu_op;
   logic        busy, done, pass, fault_flag;
   logic [15:0] fault_count;
   logic [9:0]  first_fail_vec;

   logic [3:0]  a4, b4, c4, gold4;
   logic [1:0]  op4;
   logic        busy4, done4, pass4, flag4;
   logic [15:0] cnt4;
   logic [9:0]  ff4;

`ifdef ALU_BIST_MISR_EN
   logic [15:0] signature, signature4;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic int ref_res(int a, int b, int op);
      case (op)
         0:       return (a + b) % 16;
         1:       return (a - b + 16) % 16;
         2:       return (a * b) % 16;
         default: return (b == 0) ? 15 : a / b;
      endcase
   endfunction

   // Behavioural ALUs with fault injection.
   assign gold_c = 4'(ref_res(int'(alu_a), int'(alu_b), int'(alu_op)));
   assign alu_c  = (fmode == 1) ? (gold_c & 4'hE) :
                   (fmode == 2) ? (gold_c ^ mask[{alu_a, alu_b, alu_op}]) : gold_c;
   assign gold4  = 4'(ref_res(int'(a4), int'(b4), int'(op4)));
   assign c4     = (fmode4 == 1) ? (gold4 & 4'hE) : gold4;

   alu_bist_ctrl #(.NUM_VECTORS(1024), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
      .busy(busy), .done(done), .pass(pass), .fault_flag(fault_flag),
      .fault_count(fault_count),
`ifdef ALU_BIST_MISR_EN
      .signature(signature),
`endif
      .first_fail_vec(first_fail_vec)
   );

   alu_bist_ctrl #(.NUM_VECTORS(4), .CNT_W(16)) dut4 (
      .clk(clk), .rst(rst), .start(start4),
      .alu_a(a4), .alu_b(b4), .alu_op(op4), .alu_c(c4),
      .busy(busy4), .done(done4), .pass(pass4), .fault_flag(flag4),
      .fault_count(cnt4),
`ifdef ALU_BIST_MISR_EN
      .signature(signature4),
`endif
      .first_fail_vec(ff4)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference over the whole run: how many vectors the faulty ALU gets wrong.
   task automatic model(input int n, input int mode, output int cnt, output int first);
      int g, act;
      cnt = 0;
      first = 0;
      for (int i = 0; i < n; i++) begin
         g = ref_res((i >> 6) & 15, (i >> 2) & 15, i & 3);
         if (mode == 1)      act = g & 14;
         else if (mode == 2) act = g ^ int'(mask[i]);
         else                act = g;
         if (act != g) begin
            if (cnt == 0) first = i;
            cnt++;
         end
      end
   endtask

   task automatic fill_mask();
      for (int i = 0; i < 1024; i++)
         mask[i] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      mask[$urandom_range(0, 1023)] = 4'h5;
   endtask

   // One full 1024-vector run; repulse_k >= 0 re-pulses start mid-run.
   task automatic run_big(input string name, input int mode, input int repulse_k,
                          output logic [15:0] sig_out);
      int k, busy_n, pulses, exp_cnt, exp_first;
      fmode = mode;
      model(1024, mode, exp_cnt, exp_first);
      sig_out = 16'h0000;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      k = 0; busy_n = 0; pulses = 0;
      while (1) begin
         if (busy) busy_n++;
         if (fault_flag) pulses++;
         if (k == 0) begin
            chk($sformatf("%s_first_vec", name), int'({alu_a, alu_b, alu_op}), 0);
`ifdef ALU_BIST_MISR_EN
            chk($sformatf("%s_sig_seed", name), int'(signature), 32'hFFFF);
`endif
         end
         if (done || k >= 2100) break;
         start = (k == repulse_k);
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      chk($sformatf("%s_done_cycle", name), k, 2048);
      chk($sformatf("%s_busy_cycles", name), busy_n, 2048);
      chk($sformatf("%s_done", name), int'(done), 1);
      chk($sformatf("%s_pass", name), int'(pass), (exp_cnt == 0) ? 1 : 0);
      chk($sformatf("%s_count", name), int'(fault_count), exp_cnt);
      chk($sformatf("%s_first_fail", name), int'(first_fail_vec), exp_first);
      chk($sformatf("%s_flag_pulses", name), pulses, exp_cnt);
      if (mode == 1) chk($sformatf("%s_first_is_3", name), int'(first_fail_vec), 3);
`ifdef ALU_BIST_MISR_EN
      sig_out = signature;
`endif
      @(negedge clk);
      chk($sformatf("%s_flag_low_done", name), int'(fault_flag), 0);
      chk($sformatf("%s_done_hold", name), int'(done), 1);
      chk($sformatf("%s_vec_hold", name), int'({alu_a, alu_b, alu_op}), 1023);
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] op;
      logic       busy;
      logic       done;
   } cyc_t;
   cyc_t tbl4 [9];

   typedef struct {
      string name;
      int    mode;
      int    repulse;
   } run_t;
   run_t runs [5];

   task automatic run_small(input string name, input int mode,
                            input int exp_cnt, input int exp_first, input int exp_pass);
      fmode4 = mode;
      @(negedge clk) start4 = 1'b1;
      @(negedge clk) start4 = 1'b0;
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("%s_vec_k%0d", name, k), int'({a4, b4, op4}),
             int'({tbl4[k].a, tbl4[k].b, tbl4[k].op}));
         chk($sformatf("%s_busy_k%0d", name, k), int'(busy4), int'(tbl4[k].busy));
         chk($sformatf("%s_done_k%0d", name, k), int'(done4), int'(tbl4[k].done));
         if (k < 8) @(negedge clk);
      end
      chk($sformatf("%s_count", name), int'(cnt4), exp_cnt);
      chk($sformatf("%s_first_fail", name), int'(ff4), exp_first);
      chk($sformatf("%s_pass", name), int'(pass4), exp_pass);
   endtask

   logic [15:0] sigs [5];
   logic [15:0] sig_tmp;

   initial begin
      // Cycle table for NUM_VECTORS = 4: A = B = 0, op steps every 2 cycles, DONE at +8.
      tbl4[0] = '{4'h0, 4'h0, 2'b00, 1'b1, 1'b0};
      tbl4[1] = '{4'h0, 4'h0, 2'b00, 1'b1, 1'b0};
      tbl4[2] = '{4'h0, 4'h0, 2'b01, 1'b1, 1'b0};
      tbl4[3] = '{4'h0, 4'h0, 2'b01, 1'b1, 1'b0};
      tbl4[4] = '{4'h0, 4'h0, 2'b10, 1'b1, 1'b0};
      tbl4[5] = '{4'h0, 4'h0, 2'b10, 1'b1, 1'b0};
      tbl4[6] = '{4'h0, 4'h0, 2'b11, 1'b1, 1'b0};
      tbl4[7] = '{4'h0, 4'h0, 2'b11, 1'b1, 1'b0};
      tbl4[8] = '{4'h0, 4'h0, 2'b11, 1'b0, 1'b1};

      runs[0] = '{"clean",   0, -1};
      runs[1] = '{"stuck",   1, -1};
      runs[2] = '{"random",  2, -1};
      runs[3] = '{"repulse", 2, 20};
      runs[4] = '{"clean2",  0, -1};

      for (int i = 0; i < 1024; i++) mask[i] = 4'h0;
      rst = 1'b1; start = 1'b0; start4 = 1'b0; fmode = 0; fmode4 = 0;
      repeat (3) @(negedge clk);
      chk("rst_vec",   int'({alu_a, alu_b, alu_op}), 0);
      chk("rst_busy",  int'(busy), 0);
      chk("rst_done",  int'(done), 0);
      chk("rst_pass",  int'(pass), 0);
      chk("rst_flag",  int'(fault_flag), 0);
      chk("rst_count", int'(fault_count), 0);
      chk("rst_first", int'(first_fail_vec), 0);
      rst = 1'b0;
      @(negedge clk);

      run_small("small_clean", 0, 0, 0, 1);
      run_small("small_stuck", 1, 1, 3, 0);

      for (int r = 0; r < 5; r++) begin
         if (runs[r].mode == 2) fill_mask();
         run_big(runs[r].name, runs[r].mode, runs[r].repulse, sig_tmp);
         sigs[r] = sig_tmp;
      end

`ifdef ALU_BIST_MISR_EN
      chk("misr_repeatable", int'(sigs[0]), int'(sigs[4]));
      chk("misr_nonzero", int'(sigs[0] != 16'h0000), 1);
      chk("misr_stuck_differs", int'(sigs[1] != sigs[0]), 1);
`endif

      // Abort during vector 100 with faults present, then rerun from scratch.
      fill_mask();
      fmode = 2;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (200) @(negedge clk);
      chk("pre_rst_vec", int'({alu_a, alu_b, alu_op}), 100);
      #2 rst = 1'b1;
      #1;
      chk("midrst_vec",   int'({alu_a, alu_b, alu_op}), 0);
      chk("midrst_busy",  int'(busy), 0);
      chk("midrst_done",  int'(done), 0);
      chk("midrst_pass",  int'(pass), 0);
      chk("midrst_flag",  int'(fault_flag), 0);
      chk("midrst_count", int'(fault_count), 0);
      chk("midrst_first", int'(first_fail_vec), 0);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_idle_busy", int'(busy), 0);
      chk("post_rst_idle_done", int'(done), 0);
      run_big("after_rst", 2, -1, sig_tmp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
